id_scoreboard: RTL and testbench

Register-dependency scoreboard and issue controller between the decode stage and execute. Tracks every integer register with an in-flight write, stalls the decoded instruction on RAW/WAW hazards, and grants issue to execute with a valid/ready handshake. Fixed-latency results retire by per-register countdown; variable-latency results (loads) retire on a writeback strobe.

---
 rtl/id_scoreboard.sv | 68 ++++++
 tb/tb_id_scoreboard.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: register write-pending scoreboard that stalls RAW/WAW hazards and grants issue to execute
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             rs1_r_ena,
  input  logic [4:0]       rs1_r_addr,
  input  logic             rs2_r_ena,
  input  logic [4:0]       rs2_r_addr,
  input  logic             rd_w_ena,
  input  logic [4:0]       rd_w_addr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             ex_ready,
  input  logic             wb_ena,
  input  logic [4:0]       wb_addr,
  input  logic             flush,
  output logic             issue,
  output logic             id_stall,
  output logic [NREG-1:0]  busy,
  output logic [5:0]       pending_cnt
);
  logic [NREG-1:0]            busy_q, busy_d, var_q, var_d, clr, beff;
  logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [5:0]                 pending_cnt_q, pending_cnt_d;
  logic                       hazard, set_rd;
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      clr[i]  = busy_q[i] & ((~var_q[i] & (cnt_q[i] == LAT_W'(1))) | (var_q[i] & wb_ena & (wb_addr == 5'(i))));
      beff[i] = busy_q[i] & ~clr[i];
    end
  end
  assign hazard   = (rs1_r_ena & beff[rs1_r_addr]) | (rs2_r_ena & beff[rs2_r_addr]) | (rd_w_ena & beff[rd_w_addr]);
  assign issue    = id_valid & ex_ready & ~hazard & ~flush;
  assign id_stall = id_valid & ~issue;
  assign set_rd   = issue & rd_w_ena & (rd_w_addr != 5'd0);
  always_comb begin
    pending_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = clr[i] ? 1'b0 : busy_q[i];
      var_d[i]  = clr[i] ? 1'b0 : var_q[i];
      cnt_d[i]  = clr[i] ? '0 : (busy_q[i] & ~var_q[i]) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
      if (i != 0 && set_rd && rd_w_addr == 5'(i)) begin
        busy_d[i] = 1'b1;
        var_d[i]  = (id_lat == '0);
        cnt_d[i]  = id_lat;
      end
      pending_cnt_d = pending_cnt_d + 6'(busy_d[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      var_q         <= '0;
      cnt_q         <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      var_q         <= var_d;
      cnt_q         <= cnt_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end
  assign busy        = busy_q;
  assign pending_cnt = pending_cnt_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: table-driven directed check of id_scoreboard issue, stall, busy and pending count
module tb_id_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, ex_ready, wb_ena, flush;
  logic [4:0] rs1_r_addr, rs2_r_addr, rd_w_addr, wb_addr;
  logic [1:0] id_lat;
  logic issue, id_stall;
  logic [31:0] busy;
  logic [5:0] pending_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    logic v, r1e, r2e, rde, er, wbe, fl;
    logic [4:0] r1, r2, rd, wba;
    logic [1:0] lat;
    logic ei, es;
    logic [31:0] eb;
    logic [5:0] ep;
  } vec_t;

  id_scoreboard #(.NREG(32), .LAT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr), .id_lat(id_lat),
    .ex_ready(ex_ready), .wb_ena(wb_ena), .wb_addr(wb_addr), .flush(flush),
    .issue(issue), .id_stall(id_stall), .busy(busy), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m(input int n);
    return 32'd1 << n;
  endfunction

  function automatic vec_t mk(input logic v, r1e, input int r1, input logic r2e, input int r2,
                              input logic rde, input int rd, input int lat, input logic er,
                              input logic wbe, input int wba, input logic fl,
                              input logic ei, es, input logic [31:0] eb, input int ep);
    vec_t x;
    x.v = v; x.r1e = r1e; x.r1 = 5'(r1); x.r2e = r2e; x.r2 = 5'(r2);
    x.rde = rde; x.rd = 5'(rd); x.lat = 2'(lat); x.er = er;
    x.wbe = wbe; x.wba = 5'(wba); x.fl = fl;
    x.ei = ei; x.es = es; x.eb = eb; x.ep = 6'(ep);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t x);
    id_valid = x.v; rs1_r_ena = x.r1e; rs1_r_addr = x.r1; rs2_r_ena = x.r2e; rs2_r_addr = x.r2;
    rd_w_ena = x.rde; rd_w_addr = x.rd; id_lat = x.lat; ex_ready = x.er;
    wb_ena = x.wbe; wb_addr = x.wba; flush = x.fl;
  endtask

  task automatic drive_rd(input logic v, input int rd, input int lat);
    apply(mk(v, 0, 0, 0, 0, v, rd, lat, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  vec_t vecs[26];

  initial begin
    vecs[0]  = mk(1,0,0, 0,0, 1,5,3, 1, 0,0, 0,  1,0, m(5), 1);
    vecs[1]  = mk(1,1,5, 0,0, 0,0,0, 1, 0,0, 0,  0,1, m(5), 1);
    vecs[2]  = mk(1,1,5, 0,0, 0,0,0, 1, 0,0, 0,  0,1, m(5), 1);
    vecs[3]  = mk(1,1,5, 0,0, 0,0,0, 1, 0,0, 0,  1,0, 0, 0);
    vecs[4]  = mk(1,0,0, 0,0, 1,6,1, 1, 0,0, 0,  1,0, m(6), 1);
    vecs[5]  = mk(1,0,0, 1,6, 0,0,0, 1, 0,0, 0,  1,0, 0, 0);
    vecs[6]  = mk(1,0,0, 0,0, 1,7,0, 1, 0,0, 0,  1,0, m(7), 1);
    vecs[7]  = mk(1,1,7, 0,0, 0,0,0, 1, 0,0, 0,  0,1, m(7), 1);
    vecs[8]  = mk(1,1,7, 0,0, 0,0,0, 1, 1,8, 0,  0,1, m(7), 1);
    vecs[9]  = mk(1,1,7, 0,0, 0,0,0, 1, 1,7, 0,  1,0, 0, 0);
    vecs[10] = mk(1,0,0, 0,0, 1,0,2, 1, 0,0, 0,  1,0, 0, 0);
    vecs[11] = mk(1,0,0, 0,0, 1,9,0, 1, 0,0, 0,  1,0, m(9), 1);
    vecs[12] = mk(1,0,0, 0,0, 1,9,1, 1, 0,0, 0,  0,1, m(9), 1);
    vecs[13] = mk(1,0,0, 0,0, 1,13,1, 0, 0,0, 0, 0,1, m(9), 1);
    vecs[14] = mk(1,0,0, 0,0, 1,13,1, 1, 0,0, 1, 0,1, m(9), 1);
    vecs[15] = mk(0,0,0, 0,0, 0,0,0, 1, 1,9, 0,  0,0, 0, 0);
    vecs[16] = mk(1,0,0, 0,0, 1,14,3, 1, 0,0, 0, 1,0, m(14), 1);
    vecs[17] = mk(0,0,0, 0,0, 0,0,0, 1, 1,14, 0, 0,0, m(14), 1);
    vecs[18] = mk(0,0,0, 0,0, 0,0,0, 1, 0,0, 0,  0,0, m(14), 1);
    vecs[19] = mk(0,0,0, 0,0, 0,0,0, 1, 0,0, 0,  0,0, 0, 0);
    vecs[20] = mk(1,0,0, 0,0, 1,15,3, 1, 0,0, 0, 1,0, m(15), 1);
    vecs[21] = mk(1,0,0, 0,0, 1,16,0, 1, 0,0, 0, 1,0, m(15)|m(16), 2);
    vecs[22] = mk(1,1,15, 0,0, 1,17,2, 1, 0,0, 0, 0,1, m(15)|m(16), 2);
    vecs[23] = mk(1,0,0, 0,0, 1,17,2, 1, 0,0, 0, 1,0, m(16)|m(17), 2);
    vecs[24] = mk(0,0,0, 0,0, 0,0,0, 1, 1,16, 0, 0,0, m(17), 1);
    vecs[25] = mk(0,0,0, 0,0, 0,0,0, 1, 0,0, 0,  0,0, 0, 0);

    drive_rd(0, 0, 0);
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_pcnt", 32'(pending_cnt), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_stall", 32'(id_stall), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_issue", i), 32'(issue), 32'(vecs[i].ei));
      chk($sformatf("v%0d_stall", i), 32'(id_stall), 32'(vecs[i].es));
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", i), busy, vecs[i].eb);
      chk($sformatf("v%0d_pcnt", i), 32'(pending_cnt), 32'(vecs[i].ep));
    end

    @(negedge clk); drive_rd(1, 10, 1); #1;
    chk("sw_issue0", 32'(issue), 1);
    @(posedge clk); #1;
    chk("sw_busy0", busy, m(10));
    @(negedge clk); drive_rd(1, 10, 2); #1;
    chk("sw_issue1", 32'(issue), 1);
    @(posedge clk); #1;
    chk("sw_busy1", busy, m(10));
    chk("sw_pcnt1", 32'(pending_cnt), 1);
    @(negedge clk); drive_rd(0, 0, 0);
    @(posedge clk); #1;
    chk("sw_busy2", busy, m(10));
    @(posedge clk); #1;
    chk("sw_busy3", busy, 0);

    @(negedge clk); drive_rd(1, 20, 0);
    @(negedge clk); drive_rd(1, 21, 3);
    @(posedge clk); #1;
    chk("mr_busy", busy, m(20) | m(21));
    chk("mr_pcnt", 32'(pending_cnt), 2);
    @(negedge clk); drive_rd(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_pcnt", 32'(pending_cnt), 0);
    chk("mr_rst_issue", 32'(issue), 0);
    chk("mr_rst_stall", 32'(id_stall), 0);
    @(negedge clk); rst_n = 1'b1;
    apply(mk(1, 1, 21, 1, 20, 1, 21, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mr_post_issue", 32'(issue), 1);
    @(posedge clk); #1;
    chk("mr_post_busy", busy, m(21));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
